// File: rtl/systolic_tile_seq.sv
// Sequencer for an N x N systolic tile: streams K operand words from the input SRAM,
// waits out the array skew, then writes N result words. Optional SEQ_PERF_CNT_EN adds perf_cycles.
module systolic_tile_seq #(
    parameter int N    = 4,
    parameter int AW   = 10,
    parameter int KW   = 10,
    parameter int ACCW = 16
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic [AW-1:0] in_base,
    input  logic [AW-1:0] out_base,
    output logic          in_cs,
    output logic [AW-1:0] in_addr,
    output logic          arr_input_en,
    output logic          arr_output_en,
    output logic          out_cs,
    output logic          out_wr,
    output logic [AW-1:0] out_addr,
    output logic          busy,
    output logic          done,
    output logic          err,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]   perf_cycles,
`endif
    output logic [1:0]    state_dbg
);

    // One counter serves all three phases, so it must hold both K-1 and 2N-1.
    localparam int CW = (KW > $clog2(2 * N)) ? KW : $clog2(2 * N);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 1);
    localparam logic [CW-1:0] STORE_LAST = CW'(N - 1);

    // Result words are N*ACCW bits wide; the sequencer only needs to know the config is sane.
    if (N < 1 || ACCW < 1) begin : g_bad_cfg
    end

    // Handshake: start is a single-cycle request honoured only in IDLE; the reply is
    // either busy rising the next cycle (accepted) or a one-cycle err pulse (k_len==0).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [KW-1:0] k_q;
    logic [KW-1:0] k_m1;
    logic [AW-1:0] out_base_q;
    logic          accept;

    assign k_m1      = k_q - KW'(1);
    assign accept    = (state == IDLE) && start && (k_len != '0);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state         <= IDLE;
            cnt           <= '0;
            k_q           <= '0;
            out_base_q    <= '0;
            in_cs         <= 1'b0;
            in_addr       <= '0;
            arr_input_en  <= 1'b0;
            arr_output_en <= 1'b0;
            out_cs        <= 1'b0;
            out_wr        <= 1'b0;
            out_addr      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            err          <= 1'b0;
            // The input SRAM returns data one cycle after its select.
            arr_input_en <= in_cs;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (k_len == '0) begin
                            err <= 1'b1;
                        end else begin
                            state      <= FEED;
                            k_q        <= k_len;
                            out_base_q <= out_base;
                            in_addr    <= in_base;
                            in_cs      <= 1'b1;
                            busy       <= 1'b1;
                            cnt        <= '0;
                        end
                    end
                end
                FEED: begin
                    if (cnt == CW'(k_m1)) begin
                        state <= DRAIN;
                        in_cs <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        in_addr <= in_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state         <= STORE;
                        cnt           <= '0;
                        arr_output_en <= 1'b1;
                        out_cs        <= 1'b1;
                        out_wr        <= 1'b1;
                        out_addr      <= out_base_q;
                        done          <= (N == 1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STORE: begin
                    if (cnt == STORE_LAST) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        arr_output_en <= 1'b0;
                        out_cs        <= 1'b0;
                        out_wr        <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b0;
                    end else begin
                        cnt      <= cnt + CW'(1);
                        out_addr <= out_addr + AW'(1);
                        // done is registered, so raise it one step ahead of the last write.
                        done     <= (CW'(cnt + CW'(1)) == STORE_LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            perf_cycles <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

    a_cs_excl: assert property (@(posedge clk) disable iff (!rst_b) !(in_cs && out_cs));
    a_done_wr: assert property (@(posedge clk) disable iff (!rst_b) done |-> out_wr);

endmodule

// File: tb/tb_systolic_tile_seq.sv
// Bench for systolic_tile_seq: per-cycle comparison against a phase-window model,
// plus literal address/latency expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_systolic_tile_seq;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int KW = 10;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [AW-1:0] in_base = '0;
  logic [AW-1:0] out_base = '0;
  logic          in_cs, arr_input_en, arr_output_en, out_cs, out_wr, busy, done, err;
  logic [AW-1:0] in_addr, out_addr;
  logic [1:0]    state_dbg;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // clock/reset block
  always #5 clk = ~clk;

  systolic_tile_seq #(.N(N), .AW(AW), .KW(KW), .ACCW(16)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .k_len(k_len),
    .in_base(in_base), .out_base(out_base),
    .in_cs(in_cs), .in_addr(in_addr), .arr_input_en(arr_input_en),
    .arr_output_en(arr_output_en), .out_cs(out_cs), .out_wr(out_wr),
    .out_addr(out_addr), .busy(busy), .done(done), .err(err),
`ifdef SEQ_PERF_CNT_EN
    .perf_cycles(perf_cycles),
`endif
    .state_dbg(state_dbg)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a run is a window of cycles d=1..K+3N after the accepting edge.
  bit            m_active = 0;
  bit            m_err = 0;
  int            m_d = 0;
  int            m_k = 0;
  logic [AW-1:0] m_ib = '0;
  logic [AW-1:0] m_ob = '0;
  logic [31:0]   m_perf = '0;

  always @(posedge clk) begin
    bit was_active;
    was_active = m_active;
    if (!rst_b) begin
      m_active = 0; m_err = 0; m_d = 0; m_perf = '0;
    end else begin
      m_err = 0;
      if (was_active) begin
        if (m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
        m_d++;
        if (m_d > m_k + 3 * N) m_active = 0;
      end
      if (!was_active && start) begin
        if (k_len == '0) m_err = 1;
        else begin
          m_active = 1; m_d = 1; m_k = int'(k_len);
          m_ib = in_base; m_ob = out_base; m_perf = '0;
        end
      end
    end
  end

  // scoreboard compare process, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      bit e_in, e_ie, e_st, e_done;
      logic [1:0] e_state;
      e_in   = m_active && m_d >= 1 && m_d <= m_k;
      e_ie   = m_active && m_d >= 2 && m_d <= m_k + 1;
      e_st   = m_active && m_d >= m_k + 2 * N + 1 && m_d <= m_k + 3 * N;
      e_done = m_active && m_d == m_k + 3 * N;
      e_state = !m_active ? 2'd0 : (m_d <= m_k) ? 2'd1 : (m_d <= m_k + 2 * N) ? 2'd2 : 2'd3;
      chk("in_cs", in_cs, e_in);
      chk("arr_input_en", arr_input_en, e_ie);
      chk("arr_output_en", arr_output_en, e_st);
      chk("out_cs", out_cs, e_st);
      chk("out_wr", out_wr, e_st);
      chk("done", done, e_done);
      chk("busy", busy, m_active);
      chk("err", err, m_err);
      chk("state_dbg", state_dbg, e_state);
      if (e_in) chk("in_addr", in_addr, AW'(m_ib + AW'(m_d - 1)));
      if (e_st) chk("out_addr", out_addr, AW'(m_ob + AW'(m_d - m_k - 2 * N - 1)));
`ifdef SEQ_PERF_CNT_EN
      chk("perf_cycles", perf_cycles, m_perf);
`endif
    end
  end

  // driver tasks
  logic [AW-1:0] obs_in[$];
  logic [AW-1:0] obs_out[$];
  logic [AW-1:0] exp_q[$];

  task automatic run(input int k, input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                     input int glitch_at, output int lat);
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); in_base = ib; out_base = ob;
    obs_in.delete(); obs_out.delete();
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      start = (lat == glitch_at);
      if (start) begin
        k_len = KW'($urandom_range(0, 30));
        in_base = AW'($urandom_range(0, 1023));
        out_base = AW'($urandom_range(0, 1023));
      end
      if (in_cs) obs_in.push_back(in_addr);
      if (out_cs) obs_out.push_back(out_addr);
      if (done) break;
      if (lat > k + 3 * N + 10) begin
        chk("done_timeout", 1'b1, 1'b0);
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic cmp_obs(input string nm, input bit use_out);
    int n;
    n = use_out ? obs_out.size() : obs_in.size();
    chk({nm, "_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk(nm, use_out ? obs_out[i] : obs_in[i], exp_q[i]);
  endtask

  initial begin
    int lat, lat2;
    logic [AW-1:0] a_in[$];
    logic [AW-1:0] a_out[$];

    // reset state
    repeat (3) @(negedge clk);
    cmp_en = 1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_state", state_dbg, 2'd0);
    @(negedge clk); rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // 1: reset held 3 cycles mid-FEED
    start = 1'b1; k_len = 10'd8; in_base = 10'h010; out_base = 10'h200;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    chk("feed_before_reset", in_cs, 1'b1);
    rst_b = 1'b0;
    @(negedge clk);
    chk("rst_in_cs", in_cs, 1'b0);
    chk("rst_in_addr", in_addr, '0);
    chk("rst_arr_input_en", arr_input_en, 1'b0);
    chk("rst_state", state_dbg, 2'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;

    // 2: N=4 K=8 directed
    run(8, 10'h010, 10'h200, 0, lat);
    chk("latency_k8", lat, 20);
    exp_q = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h014, 10'h015, 10'h016, 10'h017};
    cmp_obs("k8_in_addr", 0);
    exp_q = '{10'h200, 10'h201, 10'h202, 10'h203};
    cmp_obs("k8_out_addr", 1);
    chk("k8_done_addr", out_addr, 10'h203);
`ifdef SEQ_PERF_CNT_EN
    repeat (3) begin
      @(negedge clk);
      chk("perf_after_done", perf_cycles, 32'd20);
    end
`endif

    // 3: address wrap
    run(4, 10'h3FE, 10'h000, 0, lat);
    exp_q = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    cmp_obs("wrap_in_addr", 0);
    run(4, 10'h010, 10'h3FE, 0, lat);
    exp_q = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    cmp_obs("wrap_out_addr", 1);
    chk("latency_k4", lat, 16);

    // 4: rejected start, then start pulsed mid-FEED
    @(negedge clk);
    start = 1'b1; k_len = '0;
    @(negedge clk); start = 1'b0;
    chk("err_pulse", err, 1'b1);
    chk("err_busy", busy, 1'b0);
    chk("err_in_cs", in_cs, 1'b0);
    @(negedge clk);
    chk("err_one_cycle", err, 1'b0);
    run(8, 10'h010, 10'h200, 3, lat);
    chk("glitch_latency", lat, 20);
    exp_q = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h014, 10'h015, 10'h016, 10'h017};
    cmp_obs("glitch_in_addr", 0);
    exp_q = '{10'h200, 10'h201, 10'h202, 10'h203};
    cmp_obs("glitch_out_addr", 1);

    // 5: back-to-back
    run(8, 10'h010, 10'h200, 0, lat);
    a_in = obs_in; a_out = obs_out;
    run(8, 10'h010, 10'h200, 0, lat2);
    chk("b2b_latency", lat2, lat);
    exp_q = a_in;  cmp_obs("b2b_in_addr", 0);
    exp_q = a_out; cmp_obs("b2b_out_addr", 1);

    // K boundaries
    run(1, 10'h123, 10'h321, 0, lat);
    chk("latency_k1", lat, 13);
    run(1023, 10'h3F0, 10'h3FD, 0, lat);
    chk("latency_kmax", lat, 1035);

    // randomized runs, random gaps, random rejected and ignored starts
    for (int r = 0; r < 16; r++) begin
      int k;
      k = $urandom_range(1, 24);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); start = 1'b1; k_len = '0;
        @(negedge clk); start = 1'b0;
      end
      run(k, AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)),
          $urandom_range(0, k), lat);
      chk("rand_latency", lat, k + 3 * N);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
